sram_overlay_fetch: RTL and testbench
=====================================

Name: sram_overlay_fetch

Overview:
Parametrised framebuffer fetch unit that turns the VGA scan position into an SRAM read address and returns an 8-bit colour index. Supports NUM_WIN rectangular overlay windows (e.g. win/lose banners, HUD panels), each with its own position, size and SRAM base, selected by fixed priority over a full-screen background. Configuration is double-buffered and committed at frame start, so no tearing. Sits between VGA_controller and the SRAM tristate path, feeding the palette_rom index mux.

Parameters:
H_RES, 640, background line pitch in pixels
V_RES, 480, visible lines (background addressed only for DrawY < V_RES)
ADDR_W, 20, SRAM word address width
DATA_W, 16, SRAM data width
NUM_WIN, 4, number of overlay windows (1..8)
BLINK_FRAMES, 30, frames per blink half-period (used only with OVERLAY_BLINK_EN)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
pix_valid  in  1  DrawX/DrawY valid this cycle
DrawX  in  10  scan column
DrawY  in  10  scan row
frame_start  in  1  one-cycle pulse at start of vertical blank; commits config
cfg_we  in  1  config write strobe
cfg_win  in  $clog2(NUM_WIN) (min 1)  target window index
cfg_field  in  3  0=x,1=y,2=w,3=h,4=base,5=enable,6=blink
cfg_wdata  in  ADDR_W  write data (x,y,w,h use low 10 bits; enable/blink bit 0)
SRAM_ADDR  out  ADDR_W  read address to SRAM
SRAM_DQ_in  in  DATA_W  data returned by SRAM (tristate read side)
idx_valid  out  1  color_index valid
color_index  out  8  SRAM_DQ_in[7:0] for the pixel
hit  out  1  pixel came from an overlay window (aligned with color_index)
hit_win  out  $clog2(NUM_WIN) (min 1)  winning window index (aligned)

Behaviour:
- Reset: all pending and active windows disabled, all fields 0, blink counter 0; SRAM_ADDR=0, idx_valid=0, color_index=0, hit=0, hit_win=0. Reset mid-stream: idx_valid low on next edge; in-flight pixels discarded.
- Config: cfg_we writes cfg_wdata into pending[cfg_win].field; cfg_win >= NUM_WIN or field 7 ignored. frame_start copies all pending to active. cfg_we and frame_start same cycle: the write is included in the commit.
- Hit test (stage 0, registered): window i hits iff enabled, w!=0, h!=0, x <= DrawX < x+w, y <= DrawY < y+h; sums computed in 11 bits (no wrap; off-screen part simply never matches). Half-open bounds. Lowest index hit wins.
- Address (stage 1, registered to SRAM_ADDR): hit -> base + (DrawX-x) + (DrawY-y)*w; no hit -> DrawX + DrawY*H_RES. Result mod 2^ADDR_W.
- Data (stage 2): SRAM_DQ_in sampled one cycle after SRAM_ADDR update.
- Latency: pix_valid at edge n -> SRAM_ADDR at n+2 -> idx_valid/color_index/hit/hit_win at n+3. Full throughput, one pixel per cycle.
- pix_valid low: bubble propagates; SRAM_ADDR and color_index hold previous value; idx_valid low 3 cycles later.
- Config changes affect hit test only after commit; pixels already in pipeline use the config active when they entered stage 0.
- OE/WE/CE not driven here (read-only, held active by top level).

Optional Feature:
OVERLAY_BLINK_EN: when defined, frame counter increments on each frame_start, phase toggles every BLINK_FRAMES frames (reset phase 0 = visible); windows with blink=1 are treated as disabled while phase=1. When undefined: no counter, field 6 writes ignored, blink bit reads as 0.

Test Plan:
- Reset, no windows, pix_valid=1 DrawX=10 DrawY=2 -> SRAM_ADDR=1290 two cycles later; SRAM_DQ_in=16'h00A5 -> color_index=8'hA5, idx_valid=1, hit=0 at n+3.
- Window0 x=220 y=150 w=200 h=200 base=307200 en=1, frame_start; DrawX=230 DrawY=160 -> SRAM_ADDR=309210, hit=1, hit_win=0; DrawX=420 DrawY=160 -> 102820, hit=0.
- Write window0 config without frame_start -> addresses stay background; pulse frame_start (also with cfg_we same cycle) -> window active from next pixel.
- Overlap: window1 x=200 y=140 w=100 h=100 base=347200 plus window0 above; DrawX=230 DrawY=160 -> window0 address 309210, hit_win=0; disable window0, commit -> 347200+30+20*100=349230, hit_win=1.
- pix_valid toggling 1,0,1 -> idx_valid 1,0,1 at +3; Reset asserted mid-stream -> idx_valid=0 next edge, window hits gone afterwards.
- OVERLAY_BLINK_EN, BLINK_FRAMES=2, window0 blink=1: hit=1 in frames 0-1, hit=0 in frames 2-3, hit=1 in frame 4.

Source files
------------

// File: rtl/sram_overlay_fetch.sv
// Framebuffer fetch: scan position -> SRAM address (background or prioritised overlay window) -> colour index.
// Optional macro OVERLAY_BLINK_EN adds a per-window blink driven by a frame counter.
module sram_overlay_fetch #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int NUM_WIN      = 4,
  parameter int BLINK_FRAMES = 30,
  localparam int WIN_W       = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic              cfg_we,
  input  logic [WIN_W-1:0]  cfg_win,
  input  logic [2:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_wdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic [DATA_W-1:0] SRAM_DQ_in,
  output logic              idx_valid,
  output logic [7:0]        color_index,
  output logic              hit,
  output logic [WIN_W-1:0]  hit_win
);

  typedef struct packed {
    logic [9:0]        x;
    logic [9:0]        y;
    logic [9:0]        w;
    logic [9:0]        h;
    logic [ADDR_W-1:0] base;
    logic              en;
    logic              blink;
  } win_cfg_t;

  typedef struct packed {
    logic              hit;
    logic [WIN_W-1:0]  win;
    logic              addr_en;
    logic [9:0]        mul_a;
    logic [ADDR_W-1:0] mul_b;
    logic [ADDR_W-1:0] add_a;
    logic [9:0]        add_b;
  } s0_t;

  typedef struct packed {
    logic              hit;
    logic [WIN_W-1:0]  win;
    logic              addr_en;
    logic [ADDR_W-1:0] prod;
    logic [ADDR_W-1:0] sum;
  } s1_t;

  win_cfg_t pend_q [NUM_WIN];
  win_cfg_t pend_d [NUM_WIN];
  win_cfg_t act_q  [NUM_WIN];
  win_cfg_t act_d  [NUM_WIN];

  logic              s0_valid_q, s1_valid_q, s2_valid_q, idx_valid_q;
  s0_t               s0_q, s0_d;
  s1_t               s1_q, s1_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              s2_hit_q, s2_hit_d;
  logic [WIN_W-1:0]  s2_win_q, s2_win_d;
  logic [7:0]        color_q, color_d;
  logic              hit_q, hit_d;
  logic [WIN_W-1:0]  hit_win_q, hit_win_d;
  logic              blink_off;

  logic unused_ok;
  assign unused_ok = ^{SRAM_DQ_in[DATA_W-1:8], 32'(BLINK_FRAMES)};

  // A write in the same cycle as frame_start lands in the committed copy.
  always_comb begin
    for (int i = 0; i < NUM_WIN; i++) begin
      pend_d[i] = pend_q[i];
      if (cfg_we && int'(cfg_win) == i) begin
        case (cfg_field)
          3'd0: pend_d[i].x    = cfg_wdata[9:0];
          3'd1: pend_d[i].y    = cfg_wdata[9:0];
          3'd2: pend_d[i].w    = cfg_wdata[9:0];
          3'd3: pend_d[i].h    = cfg_wdata[9:0];
          3'd4: pend_d[i].base = cfg_wdata;
          3'd5: pend_d[i].en   = cfg_wdata[0];
`ifdef OVERLAY_BLINK_EN
          3'd6: pend_d[i].blink = cfg_wdata[0];
`endif
          default: ;
        endcase
      end
      act_d[i] = frame_start ? pend_d[i] : act_q[i];
    end
  end

`ifdef OVERLAY_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_off = phase_q;
`else
  assign blink_off = 1'b0;
`endif

  // Bounds in 11 bits so a window hanging off the right/bottom edge never wraps.
  logic [NUM_WIN-1:0] win_hit;
  generate
    for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_hit
      logic [10:0] x_end, y_end;
      assign x_end = {1'b0, act_q[gi].x} + {1'b0, act_q[gi].w};
      assign y_end = {1'b0, act_q[gi].y} + {1'b0, act_q[gi].h};
      assign win_hit[gi] = act_q[gi].en && !(act_q[gi].blink && blink_off) &&
                           (act_q[gi].w != '0) && (act_q[gi].h != '0) &&
                           (DrawX >= act_q[gi].x) && ({1'b0, DrawX} < x_end) &&
                           (DrawY >= act_q[gi].y) && ({1'b0, DrawY} < y_end);
    end
  endgenerate

  logic             sel_hit;
  logic [WIN_W-1:0] sel_win;
  win_cfg_t         sel_cfg;

  always_comb begin
    sel_hit = 1'b0;
    sel_win = '0;
    sel_cfg = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (win_hit[i]) begin
        sel_hit = 1'b1;
        sel_win = WIN_W'(i);
        sel_cfg = act_q[i];
      end
    end
  end

  // Stage 0 captures multiply/add operands so later stages never look at live config.
  always_comb begin
    s0_d = s0_q;
    if (pix_valid) begin
      s0_d.hit     = sel_hit;
      s0_d.win     = sel_win;
      s0_d.addr_en = sel_hit || (int'(DrawY) < V_RES);
      if (sel_hit) begin
        s0_d.mul_a = DrawY - sel_cfg.y;
        s0_d.mul_b = ADDR_W'(sel_cfg.w);
        s0_d.add_a = sel_cfg.base;
        s0_d.add_b = DrawX - sel_cfg.x;
      end else begin
        s0_d.mul_a = DrawY;
        s0_d.mul_b = ADDR_W'(H_RES);
        s0_d.add_a = '0;
        s0_d.add_b = DrawX;
      end
    end
  end

  always_comb begin
    s1_d = s1_q;
    if (s0_valid_q) begin
      s1_d.hit     = s0_q.hit;
      s1_d.win     = s0_q.win;
      s1_d.addr_en = s0_q.addr_en;
      s1_d.prod    = ADDR_W'(s0_q.mul_a) * s0_q.mul_b;
      s1_d.sum     = s0_q.add_a + ADDR_W'(s0_q.add_b);
    end
  end

  // Rows below the visible area with no window leave the address where it was.
  always_comb begin
    sram_addr_d = sram_addr_q;
    s2_hit_d    = s2_hit_q;
    s2_win_d    = s2_win_q;
    if (s1_valid_q) begin
      if (s1_q.addr_en) sram_addr_d = s1_q.prod + s1_q.sum;
      s2_hit_d = s1_q.hit;
      s2_win_d = s1_q.hit ? s1_q.win : '0;
    end
  end

  always_comb begin
    color_d   = color_q;
    hit_d     = hit_q;
    hit_win_d = hit_win_q;
    if (s2_valid_q) begin
      color_d   = SRAM_DQ_in[7:0];
      hit_d     = s2_hit_q;
      hit_win_d = s2_win_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      idx_valid_q <= 1'b0;
      s0_q        <= '0;
      s1_q        <= '0;
      sram_addr_q <= '0;
      s2_hit_q    <= 1'b0;
      s2_win_q    <= '0;
      color_q     <= '0;
      hit_q       <= 1'b0;
      hit_win_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_WIN; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
      s0_valid_q  <= pix_valid;
      s1_valid_q  <= s0_valid_q;
      s2_valid_q  <= s1_valid_q;
      idx_valid_q <= s2_valid_q;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      sram_addr_q <= sram_addr_d;
      s2_hit_q    <= s2_hit_d;
      s2_win_q    <= s2_win_d;
      color_q     <= color_d;
      hit_q       <= hit_d;
      hit_win_q   <= hit_win_d;
    end
  end

  assign SRAM_ADDR   = sram_addr_q;
  assign idx_valid   = idx_valid_q;
  assign color_index = color_q;
  assign hit         = hit_q;
  assign hit_win     = hit_win_q;

endmodule

// File: tb/tb_sram_overlay_fetch.sv
// Bench for sram_overlay_fetch: directed vector table, hand-written config/reset sequences, then random traffic vs a model.
`timescale 1ns/1ps
module tb_sram_overlay_fetch;
  localparam int NW = 4;
  localparam int AW = 20;
`ifdef OVERLAY_BLINK_EN
  localparam int BF = 2;
`else
  localparam int BF = 30;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        frame_start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_win = '0;
  logic [2:0]  cfg_field = '0;
  logic [19:0] cfg_wdata = '0;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in;
  logic        idx_valid;
  logic [7:0]  color_index;
  logic        hit;
  logic [1:0]  hit_win;

  sram_overlay_fetch #(
    .H_RES(640), .V_RES(480), .ADDR_W(AW), .DATA_W(16), .NUM_WIN(NW), .BLINK_FRAMES(BF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_win(cfg_win), .cfg_field(cfg_field),
    .cfg_wdata(cfg_wdata), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in),
    .idx_valid(idx_valid), .color_index(color_index), .hit(hit), .hit_win(hit_win)
  );

  always #10 Clk = ~Clk;

  // Address-dependent SRAM contents so colour checks confirm which word was fetched.
  function automatic logic [15:0] sram_word(input logic [19:0] a);
    return {a[15:8] ^ 8'h3C, a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A};
  endfunction
  assign SRAM_DQ_in = sram_word(SRAM_ADDR);

  typedef struct {
    int x;
    int y;
    bit eh;
    int ew;
    int ea;
  } vec_t;
  vec_t dir [15];

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int mp [NW][7];
  int ma [NW][7];
  int fcnt = 0;
  int last_addr = 0;
  int last_color = 0;
  bit sl_achk [8];
  int sl_a    [8];
  bit sl_iv   [8];
  int sl_oa   [8];
  bit sl_oh   [8];
  int sl_ow   [8];
  bit sl_rst  [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  function automatic void model_pixel(input int x, input int y, output bit h, output int w,
                                      output int a, output bit ae);
    bit vis;
    h = 0; w = 0;
    for (int i = 0; i < NW; i++) begin
      vis = (ma[i][5] != 0);
`ifdef OVERLAY_BLINK_EN
      if (ma[i][6] != 0 && ((fcnt / BF) % 2) == 1) vis = 0;
`endif
      if (!h && vis && ma[i][2] != 0 && ma[i][3] != 0 &&
          x >= ma[i][0] && x < ma[i][0] + ma[i][2] &&
          y >= ma[i][1] && y < ma[i][1] + ma[i][3]) begin
        h = 1; w = i;
      end
    end
    if (h) a = ma[w][4] + (x - ma[w][0]) + (y - ma[w][1]) * ma[w][2];
    else   a = x + y * 640;
    a = a % (1 << AW);
    ae = h || (y < 480);
  endfunction

  // One clock: schedule expectations for the inputs now on the pins, apply the edge, check at negedge.
  task automatic tick(input bit use_tbl, input bit eh, input int ew, input int ea);
    int k, s2, s3, s, ma_w, ma_a, f;
    bit mh, mae;
    logic [15:0] wd;
    k = ecnt + 1; s2 = (k + 2) % 8; s3 = (k + 3) % 8;
    if (Reset) begin
      for (int j = 0; j < 8; j++) begin
        sl_achk[j] = 0; sl_iv[j] = 0; sl_rst[j] = 0;
      end
      sl_rst[k % 8] = 1;
      for (int i = 0; i < NW; i++)
        for (int j = 0; j < 7; j++) begin mp[i][j] = 0; ma[i][j] = 0; end
      fcnt = 0; last_addr = 0;
    end else begin
      if (pix_valid) begin
        model_pixel(int'(DrawX), int'(DrawY), mh, ma_w, ma_a, mae);
        if (use_tbl) begin mh = eh; ma_w = ew; ma_a = ea; mae = 1; end
        if (mae) last_addr = ma_a;
      end
      sl_achk[s2] = 1; sl_a[s2] = last_addr;
      sl_iv[s3] = pix_valid; sl_oa[s3] = last_addr; sl_oh[s3] = mh; sl_ow[s3] = ma_w;
      f = int'(cfg_field);
`ifdef OVERLAY_BLINK_EN
      if (cfg_we && f < 7) begin
`else
      if (cfg_we && f < 6) begin
`endif
        mp[cfg_win][f] = (f < 4) ? int'(cfg_wdata[9:0]) : (f == 4) ? int'(cfg_wdata) : int'(cfg_wdata[0]);
      end
      if (frame_start) begin
        ma = mp;
        fcnt++;
      end
    end
    @(posedge Clk);
    ecnt++;
    @(negedge Clk);
    s = ecnt % 8;
    if (sl_rst[s]) begin
      chk("rst_idx_valid", idx_valid, 0);
      chk("rst_sram_addr", SRAM_ADDR, 0);
      chk("rst_color", color_index, 0);
      chk("rst_hit", hit, 0);
      chk("rst_hit_win", hit_win, 0);
      last_color = 0;
      sl_rst[s] = 0;
    end else begin
      chk("idx_valid", idx_valid, sl_iv[s]);
      if (sl_achk[s]) chk("sram_addr", SRAM_ADDR, sl_a[s]);
      if (sl_iv[s]) begin
        wd = sram_word(sl_oa[s][19:0]);
        last_color = int'(wd[7:0]);
        chk("hit", hit, sl_oh[s]);
        if (sl_oh[s]) chk("hit_win", hit_win, sl_ow[s]);
      end
      chk("color_index", color_index, last_color);
    end
    sl_achk[s] = 0; sl_iv[s] = 0;
    Reset = 0; pix_valid = 0; cfg_we = 0; frame_start = 0;
  endtask

  task automatic px_tbl(input int i);
    pix_valid = 1; DrawX = 10'(dir[i].x); DrawY = 10'(dir[i].y);
    $display("vec %0d: x=%0d y=%0d expect hit=%0d win=%0d addr=%0d",
             i, dir[i].x, dir[i].y, dir[i].eh, dir[i].ew, dir[i].ea);
    tick(1, dir[i].eh, dir[i].ew, dir[i].ea);
  endtask

  task automatic cfg(input int w, input int f, input int d, input bit fs);
    cfg_we = 1; cfg_win = 2'(w); cfg_field = 3'(f); cfg_wdata = 20'(d); frame_start = fs;
    tick(0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  initial begin
    dir[0]  = '{10, 2, 0, 0, 1290};
    dir[1]  = '{230, 160, 0, 0, 102630};
    dir[2]  = '{230, 160, 1, 0, 309210};
    dir[3]  = '{420, 160, 0, 0, 102820};
    dir[4]  = '{219, 160, 0, 0, 102619};
    dir[5]  = '{419, 349, 1, 0, 347199};
    dir[6]  = '{419, 350, 0, 0, 224419};
    dir[7]  = '{230, 160, 1, 0, 309210};
    dir[8]  = '{205, 145, 1, 1, 347705};
    dir[9]  = '{230, 160, 1, 1, 349230};
    dir[10] = '{299, 239, 1, 1, 357199};
    dir[11] = '{300, 239, 0, 0, 153260};
    dir[12] = '{5, 480, 0, 0, 153260};
    dir[13] = '{230, 160, 1, 1, 349230};
    dir[14] = '{230, 160, 0, 0, 102630};

    Reset = 1; tick(0, 0, 0, 0);
    Reset = 1; tick(0, 0, 0, 0);
    px_tbl(0); idle(4);

    cfg(0, 0, 220, 0); cfg(0, 1, 150, 0); cfg(0, 2, 200, 0); cfg(0, 3, 200, 0);
    cfg(0, 4, 307200, 0); cfg(0, 5, 1, 0);
    px_tbl(1); idle(1);
    frame_start = 1; tick(0, 0, 0, 0);
    for (int i = 2; i <= 6; i++) px_tbl(i);
    idle(3);

    cfg(1, 0, 200, 0); cfg(1, 1, 140, 0); cfg(1, 2, 100, 0); cfg(1, 3, 100, 0);
    cfg(1, 4, 347200, 0);
    cfg(1, 5, 1, 1);
    px_tbl(7); idle(1); px_tbl(8);
    cfg(0, 5, 0, 1);
    for (int i = 9; i <= 12; i++) px_tbl(i);
    cfg(1, 7, 0, 1);
`ifndef OVERLAY_BLINK_EN
    cfg(1, 6, 1, 1);
`endif
    px_tbl(13); px_tbl(13);
    Reset = 1; tick(0, 0, 0, 0);
    idle(1);
    px_tbl(14); idle(4);

`ifdef OVERLAY_BLINK_EN
    cfg(0, 0, 0, 0); cfg(0, 1, 0, 0); cfg(0, 2, 10, 0); cfg(0, 3, 10, 0);
    cfg(0, 4, 1000, 0); cfg(0, 6, 1, 0);
    Reset = 1; tick(0, 0, 0, 0);
    cfg(0, 2, 10, 0); cfg(0, 3, 10, 0); cfg(0, 4, 1000, 0); cfg(0, 6, 1, 0); cfg(0, 5, 1, 0);
    for (int fr = 0; fr < 5; fr++) begin
      pix_valid = 1; DrawX = 10'd3; DrawY = 10'd3; tick(0, 0, 0, 0);
      idle(3);
      frame_start = 1; tick(0, 0, 0, 0);
    end
    idle(4);
`endif

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) Reset = 1;
      pix_valid = ($urandom_range(0, 3) != 0);
      DrawX = 10'($urandom_range(0, 639));
      DrawY = 10'($urandom_range(0, 524));
      if ($urandom_range(0, 4) == 0) begin
        cfg_we = 1;
        cfg_win = 2'($urandom_range(0, 3));
        cfg_field = 3'($urandom_range(0, 7));
        case (cfg_field)
          3'd0: cfg_wdata = 20'($urandom_range(0, 600));
          3'd1: cfg_wdata = 20'($urandom_range(0, 500));
          3'd2, 3'd3: cfg_wdata = 20'($urandom_range(0, 200));
          3'd4: cfg_wdata = 20'($urandom);
          default: cfg_wdata = 20'($urandom_range(0, 3));
        endcase
      end
      frame_start = ($urandom_range(0, 19) == 0);
      tick(0, 0, 0, 0);
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
